// File: rtl/ps2_line_buffer.sv
// PS/2 scan-code line editor: buffers ASCII characters and drains the line as packed words on Enter.
// Define PS2_LINE_SHIFT_EN to enable shift tracking, lowercase letters and the shifted '!' and '_'.
module ps2_line_buffer #(
  parameter int DEPTH          = 32,
  parameter int CHARS_PER_WORD = 4,
  parameter int WORD_W         = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                ps2_info,
  input  logic                      ps2_enable,
  output logic [WORD_W-1:0]         out_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [WORD_W-1:0]         window,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy,
  output logic                      overflow
);
  localparam int          AW  = $clog2(DEPTH);
  localparam int          CW  = AW + 1;
  localparam int unsigned CPW = CHARS_PER_WORD;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t      state;
  logic        brk, ext;
  logic [7:0]  mem [DEPTH];
  logic [CW-1:0] rd_base, next_base;
  logic        is_make, char_ok, do_write;
  logic [7:0]  ch;
`ifdef PS2_LINE_SHIFT_EN
  logic        lshift, rshift;
`endif

  function automatic logic [8:0] translate(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, 8'h41}; 8'h32: return {1'b1, 8'h42}; 8'h21: return {1'b1, 8'h43};
      8'h23: return {1'b1, 8'h44}; 8'h24: return {1'b1, 8'h45}; 8'h2B: return {1'b1, 8'h46};
      8'h34: return {1'b1, 8'h47}; 8'h33: return {1'b1, 8'h48}; 8'h43: return {1'b1, 8'h49};
      8'h3B: return {1'b1, 8'h4A}; 8'h42: return {1'b1, 8'h4B}; 8'h4B: return {1'b1, 8'h4C};
      8'h3A: return {1'b1, 8'h4D}; 8'h31: return {1'b1, 8'h4E}; 8'h44: return {1'b1, 8'h4F};
      8'h4D: return {1'b1, 8'h50}; 8'h15: return {1'b1, 8'h51}; 8'h2D: return {1'b1, 8'h52};
      8'h1B: return {1'b1, 8'h53}; 8'h2C: return {1'b1, 8'h54}; 8'h3C: return {1'b1, 8'h55};
      8'h2A: return {1'b1, 8'h56}; 8'h1D: return {1'b1, 8'h57}; 8'h22: return {1'b1, 8'h58};
      8'h35: return {1'b1, 8'h59}; 8'h1A: return {1'b1, 8'h5A};
      8'h45: return {1'b1, 8'h30}; 8'h16: return {1'b1, 8'h31}; 8'h1E: return {1'b1, 8'h32};
      8'h26: return {1'b1, 8'h33}; 8'h25: return {1'b1, 8'h34}; 8'h2E: return {1'b1, 8'h35};
      8'h36: return {1'b1, 8'h36}; 8'h3D: return {1'b1, 8'h37}; 8'h3E: return {1'b1, 8'h38};
      8'h46: return {1'b1, 8'h39};
      8'h29: return {1'b1, 8'h20}; 8'h4E: return {1'b1, 8'h2D};
      8'h54: return {1'b1, 8'h5B}; 8'h5B: return {1'b1, 8'h5D};
      default: return '0;
    endcase
  endfunction

  // Bytes at or beyond count read as 0x00 so the last word is zero-padded.
  function automatic logic [WORD_W-1:0] pack(input logic [CW-1:0] base);
    logic [WORD_W-1:0] w;
    int unsigned idx;
    w = '0;
    for (int unsigned k = 0; k < CPW; k++) begin
      idx = 32'(base) + k;
      if (idx < 32'(count)) w[WORD_W-1-8*k -: 8] = mem[idx[AW-1:0]];
    end
    return w;
  endfunction

  always_comb begin
    is_make = ps2_enable && ps2_info != 8'hF0 && ps2_info != 8'hE0 && !brk && !ext;
    {char_ok, ch} = translate(ps2_info);
`ifdef PS2_LINE_SHIFT_EN
    if (lshift || rshift) begin
      if (ps2_info == 8'h16) ch = 8'h21;
      if (ps2_info == 8'h4E) ch = 8'h5F;
    end else if (ch >= 8'h41 && ch <= 8'h5A) begin
      ch = ch | 8'h20;
    end
`endif
    do_write  = is_make && state == COLLECT && char_ok && count != CW'(DEPTH);
    next_base = rd_base + CW'(CPW);
  end

  always_ff @(posedge clock) begin
    if (do_write) mem[count[AW-1:0]] <= ch;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= COLLECT;
      brk       <= 1'b0;
      ext       <= 1'b0;
      rd_base   <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      window    <= '0;
      count     <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
`ifdef PS2_LINE_SHIFT_EN
      lshift    <= 1'b0;
      rshift    <= 1'b0;
`endif
    end else begin
      if (ps2_enable) begin
        if (ps2_info == 8'hF0) brk <= 1'b1;
        else if (ps2_info == 8'hE0) ext <= 1'b1;
        else begin
          brk <= 1'b0;
          ext <= 1'b0;
`ifdef PS2_LINE_SHIFT_EN
          if (!ext && ps2_info == 8'h12) lshift <= !brk;
          if (!ext && ps2_info == 8'h59) rshift <= !brk;
`endif
        end
      end

      if (is_make && state == COLLECT) begin
        if (ps2_info == 8'h66) begin
          if (count != '0) begin
            count  <= count - 1'b1;
            window <= {8'h00, window[WORD_W-1:8]};
          end
        end else if (ps2_info == 8'h5A) begin
          if (count != '0) begin
            state     <= DRAIN;
            busy      <= 1'b1;
            rd_base   <= '0;
            out_word  <= pack('0);
            out_valid <= 1'b1;
            out_last  <= 32'(count) <= CPW;
          end
        end else if (char_ok) begin
          if (count != CW'(DEPTH)) begin
            count  <= count + 1'b1;
            window <= {window[WORD_W-9:0], ch};
          end else begin
            overflow <= 1'b1;
          end
        end
      end

      if (state == DRAIN && out_valid && out_ready) begin
        if (out_last) begin
          state     <= COLLECT;
          busy      <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          out_word  <= '0;
          count     <= '0;
          overflow  <= 1'b0;
          window    <= '0;
        end else begin
          rd_base  <= next_base;
          out_word <= pack(next_base);
          out_last <= 32'(next_base) + CPW >= 32'(count);
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_line_buffer.sv
// Directed self-checking bench for ps2_line_buffer (default parameters).
module tb_ps2_line_buffer;
  localparam int DEPTH = 32;
`ifdef PS2_LINE_SHIFT_EN
  localparam logic [7:0] LC = 8'h20;
`else
  localparam logic [7:0] LC = 8'h00;
`endif
  localparam logic [7:0] CA = 8'h41 | LC, CB = 8'h42 | LC, CC = 8'h43 | LC,
                         CD = 8'h44 | LC, CE = 8'h45 | LC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ps2_info = '0;
  logic        ps2_enable = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] out_word, window;
  logic        out_valid, out_last, busy, overflow;
  logic [5:0]  count;
  int total = 0, bad = 0;
  int words, last_at;

  always #5 clock = ~clock;

  ps2_line_buffer #(.DEPTH(DEPTH), .CHARS_PER_WORD(4), .WORD_W(32)) dut (
    .clock(clock), .reset(reset), .ps2_info(ps2_info), .ps2_enable(ps2_enable),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .window(window), .count(count), .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] code);
    @(negedge clock);
    ps2_info = code;
    ps2_enable = 1'b1;
    @(negedge clock);
    ps2_enable = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_window", window, 0);
    chk("rst_word", {out_word, out_last}, 0);

    // C A B, Enter
    send(8'h21); send(8'h1C); send(8'h32);
    chk("cab_count", count, 3);
    chk("cab_window", window, {8'h00, CC, CA, CB});
    send(8'h5A);
    chk("cab_valid", out_valid, 1);
    chk("cab_busy", busy, 1);
    chk("cab_word", out_word, {CC, CA, CB, 8'h00});
    chk("cab_last", out_last, 1);
    @(negedge clock);
    chk("cab_done_valid", out_valid, 0);
    chk("cab_done_count", count, 0);
    chk("cab_done_window", window, 0);
    chk("cab_done_busy", busy, 0);

    // release ignored; E0-prefixed make ignored; dropped code
    send(8'h21); send(8'hF0); send(8'h21); send(8'h1C);
    send(8'hE0); send(8'h1C); send(8'h76);
    chk("brk_count", count, 2);
    chk("brk_window", window, {16'h0000, CC, CA});
    send(8'h5A);
    chk("brk_word", out_word, {CC, CA, 16'h0000});
    chk("brk_last", out_last, 1);
    @(negedge clock);

    // digits, space, minus
    send(8'h16); send(8'h45); send(8'h29); send(8'h4E);
    send(8'h5A);
    chk("dig_word", out_word, 32'h3130202D);
    @(negedge clock);

    // two-word line with stall
    out_ready = 1'b0;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    send(8'h5A);
    chk("stall_w0", out_word, {CA, CB, CC, CD});
    chk("stall_last0", out_last, 0);
    repeat (3) @(negedge clock);
    chk("stall_hold_word", out_word, {CA, CB, CC, CD});
    chk("stall_hold_valid", {out_valid, out_last}, 2'b10);
    out_ready = 1'b1;
    @(negedge clock);
    chk("stall_w1", out_word, {CE, 24'h000000});
    chk("stall_last1", {out_valid, out_last}, 2'b11);
    @(negedge clock);
    chk("stall_done", {out_valid, busy}, 0);

    // overflow
    for (int i = 0; i < DEPTH + 2; i++) send(8'h1C);
    chk("ovf_count", count, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_window", window, {CA, CA, CA, CA});
    send(8'h5A);
    words = 0; last_at = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        words++;
        if (out_last) last_at = words;
      end
      if (!busy) break;
      @(negedge clock);
    end
    chk("ovf_words", words, 8);
    chk("ovf_last_at", last_at, 8);
    chk("ovf_cleared", {overflow, busy, count}, 0);

    // backspace and empty Enter
    send(8'h1C);
    chk("bs_count1", count, 1);
    send(8'h66);
    chk("bs_count0", count, 0);
    chk("bs_window", window, 0);
    send(8'h66);
    chk("bs_empty", count, 0);
    send(8'h5A);
    @(negedge clock);
    chk("bs_enter_ignored", {out_valid, busy}, 0);

    // reset mid-drain
    out_ready = 1'b0;
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    send(8'h5A);
    chk("mid_valid", out_valid, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst", {out_valid, busy, count}, 0);
    out_ready = 1'b1;
    send(8'h21); send(8'h5A);
    chk("mid_after_word", out_word, {CC, 24'h000000});
    chk("mid_after_last", {out_valid, out_last}, 2'b11);
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
